// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a show-ahead FIFO as framed bursts (o_sop/o_eop) on a valid/ready stream.
// Latency: start condition sampled at edge N -> first word (o_val, o_sop) in cycle N+1; one word per cycle after that.
// Backpressure: o_rdy low holds o_dat/o_sop/o_eop/o_val; the FIFO is popped only on o_val & o_rdy.
//
// Optional feature macro: FIFO_BURST_READER_TIMEOUT_EN
//   defined   -> an idle timer flushes a partial burst (1..BURST-1 words) after TIMEOUT idle cycles
//   undefined -> only full BURST-length bursts are emitted; TIMEOUT is ignored
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   clear             synchronous abort back to IDLE (truncates a burst without o_eop)
//   fifo_used         FIFO occupancy, $clog2(DEPTH+1) bits
//   fifo_rd_data      FIFO head word (show-ahead)
//   fifo_rd_empty     FIFO empty flag
//   fifo_rd_ack       pop strobe to the FIFO
//   o_dat/o_val       stream data / valid
//   o_sop/o_eop       first / last word of the burst
//   o_rdy             stream ready from the consumer
module fifo_burst_reader #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [$clog2(DEPTH+1)-1:0] fifo_used,
  input  logic [WIDTH-1:0]           fifo_rd_data,
  input  logic                       fifo_rd_empty,
  output logic                       fifo_rd_ack,
  output logic [WIDTH-1:0]           o_dat,
  output logic                       o_val,
  output logic                       o_sop,
  output logic                       o_eop,
  input  logic                       o_rdy
);

  localparam int UW = $clog2(DEPTH+1);
  localparam int CW = $clog2(BURST+1);
  // BURST <= DEPTH, so BURST always fits the occupancy width.
  localparam logic [UW-1:0] BURST_U = UW'(BURST);
  localparam logic [CW-1:0] BURST_C = CW'(BURST);

  if (BURST < 1 || BURST > DEPTH || TIMEOUT < 1) begin : g_param_check
    $error("fifo_burst_reader: need 1 <= BURST <= DEPTH and TIMEOUT >= 1");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_len;
  logic            w_full;
  logic            w_timeout;
  logic            w_start;
  logic            w_xfer;
  logic            w_last;

  assign w_full  = (fifo_used >= BURST_U);
  assign w_start = (r_state == S_IDLE) && (w_full || w_timeout);
  assign w_xfer  = o_val && o_rdy;
  assign w_last  = (r_cnt == w_len - CW'(1));

  // Data path is a straight mirror of the FIFO head, in every state.
  assign o_dat = fifo_rd_data;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);

  logic [TW-1:0] r_timer;
  logic [CW-1:0] r_len;

  // Full-burst start wins over the flush, hence the ~w_full term.
  assign w_timeout = (r_state == S_IDLE) && (r_timer == TW'(TIMEOUT-1)) &&
                     !fifo_rd_empty && !w_full;

  // Idle timer: counts only while a partial burst sits in the FIFO in IDLE.
  // It never wraps because reaching TIMEOUT-1 moves the FSM to SEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (clear || (r_state == S_SEND) || fifo_rd_empty || w_full || w_timeout) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TW'(1);
    end
  end

  // Burst length is frozen at start; words written during SEND wait for the next burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len <= '0;
    end else if (clear) begin
      r_len <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_full) begin
        r_len <= BURST_C;
      end else if (w_timeout) begin
        // fifo_used < BURST here, so it fits the length width.
        r_len <= CW'(fifo_used);
      end
    end
  end

  assign w_len = r_len;
`else
  assign w_timeout = 1'b0;
  assign w_len     = BURST_C;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_xfer && w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // o_val gating on empty is defensive: len <= fifo_used at start keeps the
  // FIFO non-empty for the whole burst.
  always_comb begin
    o_val       = 1'b0;
    o_sop       = 1'b0;
    o_eop       = 1'b0;
    fifo_rd_ack = 1'b0;
    if (r_state == S_SEND) begin
      o_val       = !fifo_rd_empty;
      o_sop       = !fifo_rd_empty && (r_cnt == '0);
      o_eop       = !fifo_rd_empty && w_last;
      fifo_rd_ack = !fifo_rd_empty && o_rdy;
    end
  end

  // Word counter within the current burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (w_start) begin
      r_cnt <= '0;
    end else if ((r_state == S_SEND) && w_xfer) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: scoreboard bench for fifo_burst_reader against a behavioural FIFO and burst-grouping model.
// Expected words are queued when written; a negedge monitor pops and compares on every o_val & o_rdy.
// Directed phases follow the block's test plan, then a randomized phase with random o_rdy backpressure.
module tb_fifo_burst_reader;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 16;
  localparam int BURST   = 4;
  localparam int TIMEOUT = 16;
  localparam int UW      = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic [UW-1:0]    fifo_used;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_empty;
  logic             fifo_rd_ack;
  logic [WIDTH-1:0] o_dat;
  logic             o_val;
  logic             o_sop;
  logic             o_eop;
  logic             o_rdy;

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .fifo_used(fifo_used), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_ack(fifo_rd_ack),
    .o_dat(o_dat), .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop), .o_rdy(o_rdy)
  );

  // ---------------- behavioural show-ahead FIFO ----------------
  logic             wr_req;
  logic [WIDTH-1:0] wr_data;
  logic             fifo_clr;
  logic [WIDTH-1:0] mem [DEPTH];
  int               wp, rp, fcount;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= 0; rp <= 0; fcount <= 0;
    end else if (fifo_clr) begin
      wp <= 0; rp <= 0; fcount <= 0;
    end else begin
      if (wr_req) begin
        mem[wp] <= wr_data;
        wp <= (wp + 1) % DEPTH;
      end
      if (fifo_rd_ack) rp <= (rp + 1) % DEPTH;
      fcount <= fcount + (wr_req ? 1 : 0) - (fifo_rd_ack ? 1 : 0);
    end
  end

  assign fifo_used     = UW'(fcount);
  assign fifo_rd_empty = (fcount == 0);
  assign fifo_rd_data  = mem[rp];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             sop;
    logic             eop;
  } exp_t;

  exp_t exp_q[$];
  int   wr_pos = 0;      // position of the next written word within its burst
  int   n_tests = 0;
  int   n_fail  = 0;
  int   xfers = 0, eops = 0, val_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  exp_t             mon_e;
  logic             prev_eop_xfer = 1'b0;
  logic             prev_hold     = 1'b0;
  logic             prev_clear    = 1'b0;
  logic [31:0]      prev_word     = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_eop_xfer) check("idle_gap_after_eop", 32'(o_val), 32'd0);
      if (prev_hold && !prev_clear)
        check("hold_stable", 32'({o_val, o_sop, o_eop, o_dat}), prev_word);
      if (o_val) val_cycles++;
      if (o_val && o_rdy) begin
        xfers++;
        if (o_eop) eops++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got dat=0x%0h sop=%0b eop=%0b, expected no transfer",
                   o_dat, o_sop, o_eop);
        end else begin
          mon_e = exp_q.pop_front();
          check("word{dat,sop,eop}", 32'({o_dat, o_sop, o_eop}), 32'({mon_e.dat, mon_e.sop, mon_e.eop}));
        end
      end
    end
    prev_eop_xfer = !reset && o_val && o_rdy && o_eop;
    prev_hold     = !reset && o_val && !o_rdy;
    prev_word     = 32'({o_val, o_sop, o_eop, o_dat});
    prev_clear    = clear;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    exp_t t;
    t.dat = d;
    t.sop = (wr_pos == 0);
    t.eop = (wr_pos == BURST-1);
    exp_q.push_back(t);
    wr_pos = (wr_pos + 1) % BURST;
    wr_req  = 1'b1;
    wr_data = d;
    tick();
    wr_req  = 1'b0;
  endtask

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  // The most recently written words go out as a short flushed burst.
  task automatic close_partial();
    exp_t t;
    t = exp_q.pop_back();
    t.eop = 1'b1;
    exp_q.push_back(t);
    wr_pos = 0;
  endtask
`endif

  task automatic wait_idle(input string name, input int bound);
    int i;
    for (i = 0; i < bound && (fcount != 0 || o_val); i++) tick();
    if (i >= bound) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: FIFO still holds %0d words, expected drain within %0d cycles",
               name, fcount, bound);
    end
    tick();
    tick();
  endtask

  // ---------------- main sequence ----------------
  logic       rnd_on = 1'b0;
  int         x0, e0, v0, w0, i;
  logic [WIDTH-1:0] d8;

  initial begin
    reset = 1'b1; clear = 1'b0; o_rdy = 1'b0;
    wr_req = 1'b0; wr_data = '0; fifo_clr = 1'b0;
    #1;
    check("reset_outputs", 32'({o_val, o_sop, o_eop, fifo_rd_ack}), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    check("post_reset_outputs", 32'({o_val, o_sop, o_eop, fifo_rd_ack}), 32'd0);

    // 1) single 4-word burst, o_rdy high, start latency and no bubbles
    o_rdy = 1'b1;
    write_word(8'hA1); write_word(8'hA2); write_word(8'hA3); write_word(8'hA4);
    check("used_reaches_burst", 32'(fifo_used), 32'd4);
    check("no_val_same_cycle", 32'(o_val), 32'd0);
    tick();
    check("start_cycle{val,sop,dat}", 32'({o_val, o_sop, o_dat}), 32'({1'b1, 1'b1, 8'hA1}));
    for (int k = 0; k < 4; k++) begin
      check("val_no_bubble", 32'(o_val), 32'd1);
      tick();
    end
    check("burst1_end_val", 32'(o_val), 32'd0);
    check("burst1_used_zero", 32'(fifo_used), 32'd0);

    // 2) same burst with o_rdy pattern 1,0,0,1,0,0,...
    o_rdy = 1'b0;
    x0 = xfers; e0 = eops;
    write_word(8'hB1); write_word(8'hB2); write_word(8'hB3); write_word(8'hB4);
    tick(); tick();
    for (i = 0; i < 40 && xfers < x0 + 4; i++) begin
      o_rdy = (i % 3 == 0);
      tick();
    end
    o_rdy = 1'b1;
    tick(); tick();
    check("toggle_ack_count", 32'(xfers - x0), 32'd4);
    check("toggle_eop_count", 32'(eops - e0), 32'd1);
    check("toggle_used_zero", 32'(fifo_used), 32'd0);

    // 3) ten words at once: two bursts and a 2-word remainder
    x0 = xfers; e0 = eops;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) d8 = WIDTH'($urandom);
      write_word((k == 8) ? d8 : WIDTH'($urandom));
    end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    close_partial();
    wait_idle("ten_words", 60);
    check("ten_words_xfers", 32'(xfers - x0), 32'd10);
    check("ten_words_eops", 32'(eops - e0), 32'd3);

    // 4) timeout flush of a 2-word partial burst
    w0 = cyc;
    write_word(8'hC1); write_word(8'hC2);
    close_partial();
    for (i = 0; i < 60 && !o_sop; i++) tick();
    check("timeout_sop_latency", 32'(cyc - w0), 32'(TIMEOUT + 1));
    wait_idle("timeout_burst", 20);
    check("timeout_used_zero", 32'(fifo_used), 32'd0);
`else
    tick(); tick(); tick(); tick();
    for (i = 0; i < 30 && exp_q.size() > 2; i++) tick();
    tick(); tick();
    check("ten_words_xfers", 32'(xfers - x0), 32'd8);
    check("ten_words_eops", 32'(eops - e0), 32'd2);
    check("remainder_used", 32'(fifo_used), 32'd2);
    check("remainder_idle_dat", 32'(o_dat), 32'(d8));

    // 4) no timeout: the remainder must stay put for 100 cycles
    v0 = val_cycles;
    for (int k = 0; k < 100; k++) tick();
    check("no_flush_without_timeout", 32'(val_cycles - v0), 32'd0);
    write_word(8'hC3); write_word(8'hC4);
    wait_idle("remainder_complete", 20);
    check("remainder_complete_used", 32'(fifo_used), 32'd0);
`endif

    // 5) clear after the 2nd transfer of a burst
    o_rdy = 1'b1;
    x0 = xfers; e0 = eops;
    write_word(8'hD1); write_word(8'hD2); write_word(8'hD3); write_word(8'hD4);
    for (i = 0; i < 20 && xfers < x0 + 2; i++) tick();
    o_rdy = 1'b0; clear = 1'b1; fifo_clr = 1'b1;
    exp_q.delete();
    wr_pos = 0;
    tick();
    clear = 1'b0; fifo_clr = 1'b0;
    check("clear_val", 32'({o_val, o_eop}), 32'd0);
    check("clear_xfers", 32'(xfers - x0), 32'd2);
    check("clear_no_eop", 32'(eops - e0), 32'd0);
    o_rdy = 1'b1;
    x0 = xfers;
    write_word(8'hE1); write_word(8'hE2); write_word(8'hE3); write_word(8'hE4);
    wait_idle("after_clear", 20);
    check("after_clear_xfers", 32'(xfers - x0), 32'd4);

    // 6) reset mid-burst
    x0 = xfers;
    write_word(8'hF1); write_word(8'hF2); write_word(8'hF3); write_word(8'hF4);
    for (i = 0; i < 20 && xfers < x0 + 1; i++) tick();
    reset = 1'b1;
    exp_q.delete();
    wr_pos = 0;
    #1;
    check("async_reset_outputs", 32'({o_val, o_sop, o_eop, fifo_rd_ack}), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    x0 = xfers;
    write_word(8'h11); write_word(8'h12); write_word(8'h13); write_word(8'h14);
    wait_idle("after_reset", 20);
    check("after_reset_xfers", 32'(xfers - x0), 32'd4);

    // 7) random chunks of BURST words with random backpressure
    x0 = xfers;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          o_rdy = ($urandom_range(0, 3) != 0);
          tick();
        end
      end
      begin
        for (int c = 0; c < 16; c++) begin
          for (i = 0; i < 200 && fcount > DEPTH - BURST; i++) tick();
          for (int k = 0; k < BURST; k++) write_word(WIDTH'($urandom));
          repeat ($urandom_range(0, 5)) tick();
        end
        rnd_on = 1'b0;
      end
    join
    o_rdy = 1'b1;
    wait_idle("random", 200);
    check("random_xfers", 32'(xfers - x0), 32'(16 * BURST));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
